// File: rtl/jtag_tap_ctrl_if.sv
// Serial JTAG pins between the driving agent (master) and the TAP controller (slave).
interface jtag_tap_ctrl_if;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    modport master (output tms, output tdi, input tdo, input tdo_en);
    modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, bypass, IDCODE and one user data register.
// Latency: state and registers change on the tck rising edge; tdo/tdo_en are combinational from state.
// Backpressure: none; the serial stream is consumed every tck cycle.
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH   = 4,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5A5B
) (
    input  logic                tck,
    input  logic                trst,
    jtag_tap_ctrl_if.slave      jtag,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] user_capture,
    output logic [DR_WIDTH-1:0] user_dr,
    output logic                user_update
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } state_t;

    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(2);

    state_t                state;
    state_t                state_nxt;
    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           id_sr;
    logic [DR_WIDTH-1:0]   user_sr;
    logic                  bypass_sr;
    logic                  sel_idcode;
    logic                  sel_user;

    function automatic state_t next_state(input state_t s, input logic t);
        state_t n;
        n = TLR;
        case (s)
            TLR:    n = t ? TLR    : RTI;
            RTI:    n = t ? SEL_DR : RTI;
            SEL_DR: n = t ? SEL_IR : CAP_DR;
            CAP_DR: n = t ? EX1_DR : SH_DR;
            SH_DR:  n = t ? EX1_DR : SH_DR;
            EX1_DR: n = t ? UPD_DR : PAU_DR;
            PAU_DR: n = t ? EX2_DR : PAU_DR;
            EX2_DR: n = t ? UPD_DR : SH_DR;
            UPD_DR: n = t ? SEL_DR : RTI;
            SEL_IR: n = t ? TLR    : CAP_IR;
            CAP_IR: n = t ? EX1_IR : SH_IR;
            SH_IR:  n = t ? EX1_IR : SH_IR;
            EX1_IR: n = t ? UPD_IR : PAU_IR;
            PAU_IR: n = t ? EX2_IR : PAU_IR;
            EX2_IR: n = t ? UPD_IR : SH_IR;
            UPD_IR: n = t ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    assign state_nxt  = next_state(state, jtag.tms);
    assign sel_idcode = (ir_out == INSTR_IDCODE);
    assign sel_user   = (ir_out == INSTR_USER);
    assign tap_state  = state;

    always_ff @(posedge tck) begin
        if (trst) begin
            state       <= TLR;
            ir_out      <= INSTR_IDCODE;
            ir_sr       <= '0;
            id_sr       <= '0;
            user_sr     <= '0;
            bypass_sr   <= 1'b0;
            user_dr     <= '0;
            user_update <= 1'b0;
        end else begin
            state       <= state_nxt;
            user_update <= 1'b0;
            case (state)
                CAP_IR: ir_sr <= IR_WIDTH'(2'b01);
                SH_IR:  ir_sr <= {jtag.tdi, ir_sr[IR_WIDTH-1:1]};
                UPD_IR: ir_out <= ir_sr;
                CAP_DR: begin
                    if (sel_idcode)    id_sr     <= IDCODE_VAL;
                    else if (sel_user) user_sr   <= user_capture;
                    else               bypass_sr <= 1'b0;
                end
                SH_DR: begin
                    if (sel_idcode)    id_sr     <= {jtag.tdi, id_sr[31:1]};
                    else if (sel_user) user_sr   <= (user_sr >> 1) | (DR_WIDTH'(jtag.tdi) << (DR_WIDTH - 1));
                    else               bypass_sr <= jtag.tdi;
                end
                UPD_DR: begin
                    if (sel_user) begin
                        user_dr     <= user_sr;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Any tms-driven entry into Test-Logic-Reset restores the IDCODE instruction.
            if (state_nxt == TLR) ir_out <= INSTR_IDCODE;
        end
    end

    always_comb begin
        jtag.tdo    = 1'b0;
        jtag.tdo_en = 1'b0;
        if (state == SH_IR) begin
            jtag.tdo    = ir_sr[0];
            jtag.tdo_en = 1'b1;
        end else if (state == SH_DR) begin
            jtag.tdo_en = 1'b1;
            if (sel_idcode)    jtag.tdo = id_sr[0];
            else if (sel_user) jtag.tdo = user_sr[0];
            else               jtag.tdo = bypass_sr;
        end
    end

endmodule
